alu_arbiter: RTL and testbench

Shares one `ALU` instance between two independent requesters, such as two issue slots or an execute stage plus an address-generation helper. Each requester has a valid/ready request channel and a one-entry registered response channel. A round-robin arbiter grants at most one request per cycle. The granted operands go through the combinational ALU, and the result is registered into that requester's response slot. Result latency is one cycle. Aggregate throughput is one operation per cycle.

---
 rtl/alu_arbiter.sv | 80 ++++++++
 tb/tb_alu_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters with registered response slots
module alu
  (
    input  logic [3:0]  op,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [5:0]  shamt,
    output logic [31:0] res
  );
  always_comb begin
    res = '0;
    case (op)
      4'b0000: res = in0 & in1;
      4'b0001: res = in0 | in1;
      4'b0010: res = in0 + in1;
      4'b0100: res = in1 << shamt;
      4'b0101: res = in1 >> shamt;
      4'b0110: res = in0 - in1;
      4'b0111: res = {31'b0, in0 < in1};
      4'b1100: res = ~(in0 | in1);
      default: res = '0;
    endcase
  end
endmodule

module alu_arbiter #(
    parameter int TAG_W = 4
  ) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [7:0]         req_op,
    input  logic [63:0]        req_in0,
    input  logic [63:0]        req_in1,
    input  logic [11:0]        req_shamt,
    input  logic [2*TAG_W-1:0] req_tag,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [63:0]        rsp_out,
    output logic [1:0]         rsp_iszero,
    output logic [2*TAG_W-1:0] rsp_tag
  );
  logic [1:0] elig, grant;
  logic prio, sel;
  logic [31:0] res;
  assign elig = req_valid & (~rsp_valid | rsp_ready);
  assign grant = rst ? 2'b00 : (&elig) ? (prio ? 2'b10 : 2'b01) : elig;
  assign req_ready = grant;
  // with no grant the ALU simply follows the preferred requester
  assign sel = grant[1] | (~grant[0] & prio);
  alu u_alu (
    .op    (sel ? req_op[7:4]       : req_op[3:0]),
    .in0   (sel ? req_in0[63:32]    : req_in0[31:0]),
    .in1   (sel ? req_in1[63:32]    : req_in1[31:0]),
    .shamt (sel ? req_shamt[11:6]   : req_shamt[5:0]),
    .res   (res)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_out    <= '0;
      rsp_iszero <= '0;
      rsp_tag    <= '0;
      prio       <= 1'b0;
    end else begin
      if (|grant) prio <= grant[0];
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          rsp_valid[i]             <= 1'b1;
          rsp_out[32*i+:32]        <= res;
          rsp_iszero[i]            <= (res == '0);
          rsp_tag[TAG_W*i+:TAG_W]  <= req_tag[TAG_W*i+:TAG_W];
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a behavioural slot/ALU model
module tb_alu_arbiter;
  localparam int TAG_W = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] vld = '0, rr = '0, rdy, rsp_valid, rsp_iszero;
  logic [3:0] op [2];
  logic [31:0] a [2], b [2];
  logic [5:0] sh [2];
  logic [TAG_W-1:0] tg [2];
  logic [63:0] rsp_out;
  logic [2*TAG_W-1:0] rsp_tag;
  bit mv [2];
  logic [31:0] mo [2];
  bit mz [2];
  logic [TAG_W-1:0] mt [2];
  bit mp;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .req_valid(vld), .req_ready(rdy),
    .req_op({op[1], op[0]}), .req_in0({a[1], a[0]}), .req_in1({b[1], b[0]}),
    .req_shamt({sh[1], sh[0]}), .req_tag({tg[1], tg[0]}),
    .rsp_valid(rsp_valid), .rsp_ready(rr), .rsp_out(rsp_out),
    .rsp_iszero(rsp_iszero), .rsp_tag(rsp_tag)
  );

  function automatic logic [31:0] alu_f(logic [3:0] o, logic [31:0] x, logic [31:0] y, logic [5:0] s);
    case (o)
      4'h0: return x & y;
      4'h1: return x | y;
      4'h2: return x + y;
      4'h4: return (s >= 32) ? 32'h0 : y << s;
      4'h5: return (s >= 32) ? 32'h0 : y >> s;
      4'h6: return x - y;
      4'h7: return (x < y) ? 32'h1 : 32'h0;
      4'hc: return ~(x | y);
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic set_req(int i, logic [3:0] o, logic [31:0] x, logic [31:0] y, logic [5:0] s, logic [TAG_W-1:0] t);
    op[i] = o; a[i] = x; b[i] = y; sh[i] = s; tg[i] = t;
  endtask

  // one clock: predict grant, check it, advance the model, check registered outputs
  task automatic cycle();
    logic [1:0] el, g;
    #1;
    for (int i = 0; i < 2; i++) el[i] = vld[i] & (!mv[i] | rr[i]);
    g = rst ? 2'b00 : (el == 2'b11) ? (mp ? 2'b10 : 2'b01) : el;
    check("req_ready", {62'b0, rdy}, {62'b0, g});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 2; i++) begin mv[i] = 0; mo[i] = 0; mz[i] = 0; mt[i] = 0; end
      mp = 0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (g[i]) begin
          mo[i] = alu_f(op[i], a[i], b[i], sh[i]);
          mz[i] = (mo[i] == 0);
          mt[i] = tg[i];
          mv[i] = 1;
        end else if (rr[i]) mv[i] = 0;
      if (g != 0) mp = (g == 2'b01);
    end
    @(negedge clk);
    check("rsp_valid", {62'b0, rsp_valid}, {62'b0, mv[1], mv[0]});
    check("rsp_out", rsp_out, {mo[1], mo[0]});
    check("rsp_iszero", {62'b0, rsp_iszero}, {62'b0, mz[1], mz[0]});
    check("rsp_tag", {56'b0, rsp_tag}, {56'b0, mt[1], mt[0]});
  endtask

  task automatic pulse_rst();
    rst = 1; cycle(); rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) set_req(i, 0, 0, 0, 0, 0);
    @(negedge clk);
    cycle(); cycle();
    rst = 0;
    // ADD wraps to zero
    set_req(0, 4'h2, 32'hffff_ffff, 32'h1, 0, 4'h5); vld = 2'b01; rr = 2'b11;
    #1 check("t1_ready", {62'b0, rdy}, 64'h1);
    cycle();
    check("t1_out", {32'b0, rsp_out[31:0]}, 64'h0);
    check("t1_zero", {63'b0, rsp_iszero[0]}, 64'h1);
    check("t1_valid", {62'b0, rsp_valid}, 64'h1);
    vld = 0; cycle();
    // alternating grants under contention
    pulse_rst();
    set_req(0, 4'h6, 32'd5, 32'd7, 0, 4'h3);
    set_req(1, 4'h7, 32'd3, 32'h8000_0000, 0, 4'h9);
    vld = 2'b11; rr = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1 check("alt_ready", {62'b0, rdy}, (k % 2) ? 64'h2 : 64'h1);
      cycle();
    end
    check("alt_out0", {32'b0, rsp_out[31:0]}, 64'hffff_fffe);
    check("alt_out1", {32'b0, rsp_out[63:32]}, 64'h1);
    check("alt_tag", {56'b0, rsp_tag}, 64'h93);
    // blocked slot 1 must not starve requester 0
    rr = 2'b01;
    for (int k = 0; k < 5; k++) begin
      #1 check("blk_ready", {62'b0, rdy}, 64'h1);
      cycle();
      check("blk_out1", {32'b0, rsp_out[63:32]}, 64'h1);
    end
    // drain and refill slot 0 in the same cycle
    set_req(0, 4'h4, 32'h0, 32'h1, 6'd31, 4'h1); vld = 2'b01;
    #1 check("ovr_ready", {62'b0, rdy}, 64'h1);
    cycle();
    check("ovr_out", {32'b0, rsp_out[31:0]}, 64'h8000_0000);
    check("ovr_valid", {63'b0, rsp_valid[0]}, 64'h1);
    set_req(0, 4'h5, 32'h0, 32'hffff_ffff, 6'd32, 4'h2); cycle();
    check("srl32_out", {32'b0, rsp_out[31:0]}, 64'h0);
    check("srl32_zero", {63'b0, rsp_iszero[0]}, 64'h1);
    set_req(0, 4'hf, 32'h1234, 32'h5678, 0, 4'h3); cycle();
    check("undef_out", {32'b0, rsp_out[31:0]}, 64'h0);
    check("undef_zero", {63'b0, rsp_iszero[0]}, 64'h1);
    set_req(0, 4'hc, 32'h0, 32'h0, 0, 4'h4); cycle();
    check("nor_out", {32'b0, rsp_out[31:0]}, 64'hffff_ffff);
    check("nor_zero", {63'b0, rsp_iszero[0]}, 64'h0);
    // reset with both slots full and both requesting
    vld = 2'b11; rr = 2'b00;
    cycle(); cycle(); cycle();
    check("full_valid", {62'b0, rsp_valid}, 64'h3);
    rst = 1;
    #1 check("rst_ready", {62'b0, rdy}, 64'h0);
    cycle();
    check("rst_valid", {62'b0, rsp_valid}, 64'h0);
    rst = 0; rr = 2'b11;
    #1 check("post_rst_tie", {62'b0, rdy}, 64'h1);
    cycle();
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        logic [3:0] o;
        o = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 7) == 3 ? 12 : $urandom_range(0, 7)) : 4'($urandom);
        set_req(i, o, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                ($urandom_range(0, 3) == 0) ? 32'hffff_ffff : $urandom, 6'($urandom), TAG_W'($urandom));
      end
      vld = 2'($urandom); rr = 2'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
